// File: rtl/reg_unit_arbiter_if.sv
// Request, response and datapath signals shared between the two requesters,
// the response consumer, the 4-bit register/ALU unit and reg_unit_arbiter.
interface reg_unit_arbiter_if #(
    parameter int DATA_W = 4,
    parameter int CTRL_W = 3
);
    logic              a_valid;
    logic [CTRL_W-1:0] a_op;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [CTRL_W-1:0] b_op;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_id;
    logic [CTRL_W-1:0] dp_control;
    logic [DATA_W-1:0] dp_data_in;
    logic [DATA_W-1:0] dp_data_out;
    logic              busy;

    // Environment side: requesters, response consumer and the unit itself.
    modport master (
        output a_valid, a_op, a_data, b_valid, b_op, b_data, rsp_ready, dp_data_out,
        input  a_ready, b_ready, rsp_valid, rsp_data, rsp_id, dp_control, dp_data_in, busy
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_op, a_data, b_valid, b_op, b_data, rsp_ready, dp_data_out,
        output a_ready, b_ready, rsp_valid, rsp_data, rsp_id, dp_control, dp_data_in, busy
    );
endinterface

// File: rtl/reg_unit_arbiter.sv
// Round-robin arbiter sharing one register/ALU unit between requesters A and B:
// grant, drive the unit for one cycle, capture its result RESULT_LAT cycles later.
module reg_unit_arbiter #(
    parameter int DATA_W     = 4,
    parameter int CTRL_W     = 3,
    parameter int RESULT_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_unit_arbiter_if.slave  bus
);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] op;
        logic [DATA_W-1:0] data;
        logic              id;
    } req_t;

    state_t            r_state;
    state_t            w_state_nxt;
    req_t              r_req;
    req_t              w_grant_req;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_data;
    logic [1:0]        w_req_valid;
    logic              w_grant;
    logic              w_grant_id;

    // Arbitration: a lone requester wins outright, a tie goes to whoever
    // did not win last. Gated by rst_n so ready stays low while in reset.
    always_comb begin
        w_req_valid = {bus.b_valid, bus.a_valid};
        case (w_req_valid)
            2'b10:   w_grant_id = 1'b1;
            2'b11:   w_grant_id = ~r_last_grant;
            default: w_grant_id = 1'b0;
        endcase
        w_grant          = rst_n && (r_state == S_IDLE) && (|w_req_valid);
        w_grant_req.id   = w_grant_id;
        w_grant_req.op   = w_grant_id ? bus.b_op   : bus.a_op;
        w_grant_req.data = w_grant_id ? bus.b_data : bus.a_data;
    end

    always_comb begin
        w_state_nxt    = r_state;
        bus.a_ready    = 1'b0;
        bus.b_ready    = 1'b0;
        bus.dp_control = '0;
        bus.dp_data_in = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_ISSUE;
                    bus.a_ready = ~w_grant_id;
                    bus.b_ready = w_grant_id;
                end
            end
            S_ISSUE: begin
                w_state_nxt    = S_WAIT;
                bus.dp_control = r_req.op;
                bus.dp_data_in = r_req.data;
            end
            S_WAIT: begin
                if (r_cnt == '0) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req        <= '0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_req        <= w_grant_req;
                        r_last_grant <= w_grant_id;
                    end
                end
                S_ISSUE: r_cnt <= CNT_W'(RESULT_LAT - 1);
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_rsp_data  <= bus.dp_data_out;
                        r_rsp_id    <= r_req.id;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_reg_unit_arbiter.sv
// Bench for reg_unit_arbiter: vector table, hand sequences for latency, backpressure
// and reset, and random traffic against a transaction-level reference model.
module tb_reg_unit_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_unit_arbiter_if #(.DATA_W(4), .CTRL_W(3)) if0 ();
    reg_unit_arbiter_if #(.DATA_W(4), .CTRL_W(3)) if1 ();

    reg_unit_arbiter #(.DATA_W(4), .CTRL_W(3), .RESULT_LAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    reg_unit_arbiter #(.DATA_W(4), .CTRL_W(3), .RESULT_LAT(3)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // Unit stubs: a NOP control holds the register, so the result survives
    // until it is captured however long RESULT_LAT is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   if0.dp_data_out <= 4'h0;
        else if (if0.dp_control != 0) if0.dp_data_out <= if0.dp_data_in ^ {1'b0, if0.dp_control};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   if1.dp_data_out <= 4'h0;
        else if (if1.dp_control != 0) if1.dp_data_out <= if1.dp_data_in ^ {1'b0, if1.dp_control};
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: who won last and what the unit register holds.
    bit       m_last = 1'b1;
    logic [3:0] m_unit = 4'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_unit = 4'h0;
    endtask

    // One full transaction on u0, entered at a negedge with u0 idle.
    task automatic txn(input bit av, input logic [2:0] ao, input logic [3:0] ad,
                       input bit bv, input logic [2:0] bo, input logic [3:0] bd,
                       input int bp, output bit gid, output logic [3:0] rdata);
        bit         ew;
        bit         got;
        logic [2:0] eop;
        logic [3:0] edata;
        logic [3:0] eres;
        ew    = (av && bv) ? !m_last : !av;
        eop   = ew ? bo : ao;
        edata = ew ? bd : ad;
        eres  = (eop != 3'b000) ? (edata ^ {1'b0, eop}) : m_unit;
        gid   = ew;
        rdata = 4'hx;
        if0.a_valid = av; if0.a_op = ao; if0.a_data = ad;
        if0.b_valid = bv; if0.b_op = bo; if0.b_data = bd;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (if0.a_ready || if0.b_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk("grant_seen", 32'(got), 32'(1));
        if (!got) return;
        chk("a_ready", 32'(if0.a_ready), 32'(!ew));
        chk("b_ready", 32'(if0.b_ready), 32'(ew));
        m_last = ew;
        if (eop != 3'b000) m_unit = eres;
        @(negedge clk);
        if (ew) if0.b_valid = 1'b0; else if0.a_valid = 1'b0;
        chk("issue_ctl", 32'(if0.dp_control), 32'(eop));
        chk("issue_din", 32'(if0.dp_data_in), 32'(edata));
        chk("issue_busy", 32'(if0.busy), 32'(1));
        chk("issue_ready", 32'({if0.a_ready, if0.b_ready}), 32'(0));
        @(negedge clk);
        chk("wait_ctl", 32'(if0.dp_control), 32'(0));
        chk("wait_rsp_valid", 32'(if0.rsp_valid), 32'(0));
        chk("wait_ready", 32'({if0.a_ready, if0.b_ready}), 32'(0));
        @(negedge clk);
        chk("rsp_valid", 32'(if0.rsp_valid), 32'(1));
        chk("rsp_data", 32'(if0.rsp_data), 32'(eres));
        chk("rsp_id", 32'(if0.rsp_id), 32'(ew));
        rdata = if0.rsp_data;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(if0.rsp_valid), 32'(1));
            chk("bp_data", 32'(if0.rsp_data), 32'(eres));
            chk("bp_id", 32'(if0.rsp_id), 32'(ew));
            chk("bp_ctl", 32'(if0.dp_control), 32'(0));
            chk("bp_ready", 32'({if0.a_ready, if0.b_ready}), 32'(0));
        end
        if0.rsp_ready = 1'b1;
        @(negedge clk);
        if0.rsp_ready = 1'b0;
        chk("done_busy", 32'(if0.busy), 32'(0));
        chk("done_rsp_valid", 32'(if0.rsp_valid), 32'(0));
    endtask

    typedef struct {
        bit         av;
        logic [2:0] ao;
        logic [3:0] ad;
        bit         bv;
        logic [2:0] bo;
        logic [3:0] bd;
        bit         eid;
        logic [3:0] edata;
    } vec_t;

    vec_t tbl [7];

    initial begin
        bit         gid;
        logic [3:0] rd;
        bit         got;
        int         lat;
        int         nonnop;

        tbl[0] = '{1'b1, 3'b010, 4'h3, 1'b1, 3'b100, 4'h5, 1'b0, 4'h1};
        tbl[1] = '{1'b0, 3'b010, 4'h3, 1'b1, 3'b100, 4'h5, 1'b1, 4'h1};
        tbl[2] = '{1'b1, 3'b001, 4'h6, 1'b0, 3'b000, 4'h0, 1'b0, 4'h7};
        tbl[3] = '{1'b0, 3'b000, 4'h0, 1'b1, 3'b110, 4'h9, 1'b1, 4'hF};
        tbl[4] = '{1'b1, 3'b111, 4'h0, 1'b1, 3'b001, 4'h1, 1'b0, 4'h7};
        tbl[5] = '{1'b1, 3'b000, 4'h5, 1'b1, 3'b000, 4'h2, 1'b1, 4'h7};
        tbl[6] = '{1'b1, 3'b011, 4'hA, 1'b0, 3'b000, 4'h0, 1'b0, 4'h9};

        if0.a_valid = 1'b1; if0.a_op = 3'b001; if0.a_data = 4'h6;
        if0.b_valid = 1'b0; if0.b_op = 3'b000; if0.b_data = 4'h0;
        if0.rsp_ready = 1'b0;
        if1.a_valid = 1'b0; if1.a_op = 3'b000; if1.a_data = 4'h0;
        if1.b_valid = 1'b0; if1.b_op = 3'b000; if1.b_data = 4'h0;
        if1.rsp_ready = 1'b0;

        // Reset values, with a request already pending.
        repeat (2) @(negedge clk);
        chk("rst_a_ready", 32'(if0.a_ready), 32'(0));
        chk("rst_busy", 32'(if0.busy), 32'(0));
        chk("rst_rsp_valid", 32'(if0.rsp_valid), 32'(0));
        chk("rst_rsp_data", 32'(if0.rsp_data), 32'(0));
        chk("rst_rsp_id", 32'(if0.rsp_id), 32'(0));
        chk("rst_ctl", 32'(if0.dp_control), 32'(0));
        chk("rst_din", 32'(if0.dp_data_in), 32'(0));
        if0.a_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(if0.busy), 32'(0));

        // Vector table: tie after reset goes to A, lone requesters, op 000.
        for (int i = 0; i < 7; i++) begin
            txn(tbl[i].av, tbl[i].ao, tbl[i].ad, tbl[i].bv, tbl[i].bo, tbl[i].bd, 0, gid, rd);
            chk($sformatf("tbl%0d_id", i), 32'(gid), 32'(tbl[i].eid));
            chk($sformatf("tbl%0d_data", i), 32'(rd), 32'(tbl[i].edata));
        end
        if0.a_valid = 1'b0; if0.b_valid = 1'b0;

        // Fairness from a fresh reset: both held valid for 8 transactions.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            txn(1'b1, 3'b101, 4'(i), 1'b1, 3'b110, 4'(i + 8), 0, gid, rd);
            chk($sformatf("fair%0d_id", i), 32'(gid), 32'(i % 2));
        end
        if0.a_valid = 1'b0; if0.b_valid = 1'b0;
        @(negedge clk);

        // Backpressure: response held for 5 cycles.
        txn(1'b1, 3'b001, 4'h8, 1'b0, 3'b000, 4'h0, 5, gid, rd);

        // Reset during WAIT: in-flight op is dropped, outputs return to reset values.
        if0.a_valid = 1'b1; if0.a_op = 3'b101; if0.a_data = 4'h2;
        #1;
        chk("mid_a_ready", 32'(if0.a_ready), 32'(1));
        @(negedge clk);
        if0.a_valid = 1'b0;
        @(negedge clk);
        chk("mid_in_wait", 32'(if0.busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(if0.busy), 32'(0));
        chk("mid_rsp_valid", 32'(if0.rsp_valid), 32'(0));
        chk("mid_rsp_data", 32'(if0.rsp_data), 32'(0));
        chk("mid_rsp_id", 32'(if0.rsp_id), 32'(0));
        chk("mid_ctl", 32'(if0.dp_control), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_no_rsp", 32'(if0.rsp_valid), 32'(0));
        end
        txn(1'b0, 3'b000, 4'h0, 1'b1, 3'b011, 4'h4, 0, gid, rd);
        chk("post_rst_id", 32'(gid), 32'(1));
        chk("post_rst_data", 32'(rd), 32'(7));
        if0.b_valid = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            bit av, bv;
            av = 1'($urandom_range(0, 1));
            bv = 1'($urandom_range(0, 1));
            if (!av && !bv) av = 1'b1;
            txn(av, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                bv, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), gid, rd);
        end
        if0.a_valid = 1'b0; if0.b_valid = 1'b0;

        // RESULT_LAT = 3 instance: single B request.
        @(negedge clk);
        if1.b_valid = 1'b1; if1.b_op = 3'b011; if1.b_data = 4'hC;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (if1.b_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk("rl3_grant", 32'(got), 32'(1));
        chk("rl3_grant_ctl", 32'(if1.dp_control), 32'(0));
        lat = 0;
        nonnop = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if1.b_valid = 1'b0;
            lat++;
            if (if1.dp_control != 3'b000) nonnop++;
            if (if1.rsp_valid) break;
        end
        chk("rl3_latency", 32'(lat), 32'(5));
        chk("rl3_data", 32'(if1.rsp_data), 32'(4'hF));
        chk("rl3_id", 32'(if1.rsp_id), 32'(1));
        chk("rl3_nonnop", 32'(nonnop), 32'(1));
        if1.rsp_ready = 1'b1;
        @(negedge clk);
        if1.rsp_ready = 1'b0;
        chk("rl3_done_busy", 32'(if1.busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
